// File: rtl/keycode_action_mapper_if.sv
// Keycode/config/jump handshake bundle between the NIOS keycode export and the mapper.
// master = keyboard/config side, slave = mapper.
interface keycode_action_mapper_if #(
   parameter int NUM_KEYS    = 6,
   parameter int NUM_PLAYERS = 2
);
   logic [8*NUM_KEYS-1:0]  keycodes;
   logic                   cfg_we;
   logic [2:0]             cfg_player;
   logic [1:0]             cfg_action;
   logic [7:0]             cfg_code;
   logic [NUM_PLAYERS-1:0] jump_ack;
   logic [NUM_PLAYERS-1:0] left;
   logic [NUM_PLAYERS-1:0] right;
   logic [NUM_PLAYERS-1:0] jump_held;
   logic [NUM_PLAYERS-1:0] jump_pulse;
   logic [NUM_PLAYERS-1:0] jump_req;
   logic                   any_key;

   modport master (
      output keycodes, cfg_we, cfg_player, cfg_action, cfg_code, jump_ack,
      input  left, right, jump_held, jump_pulse, jump_req, any_key
   );
   modport slave (
      input  keycodes, cfg_we, cfg_player, cfg_action, cfg_code, jump_ack,
      output left, right, jump_held, jump_pulse, jump_req, any_key
   );
endinterface

// File: rtl/keycode_action_mapper.sv
// Maps parallel HID keycode slots onto per-player left/right/jump actions,
// sampled once per synchronised frame strobe, with a programmable key table.

module keycode_action_mapper_lane #(
   parameter int NUM_KEYS = 6,
   parameter int JUMP_BUF = 4,
   parameter int LR_MODE  = 0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  tick,
   input  logic [8*NUM_KEYS-1:0] keycodes,
   input  logic [2:0][7:0]       codes,    // [0]=left [1]=right [2]=jump
   input  logic                  ack,
   output logic                  left,
   output logic                  right,
   output logic                  jump_held,
   output logic                  jump_pulse,
   output logic                  jump_req
);
   logic       lp, rp, jp;
   logic       l_prev, r_prev, j_prev;
   logic       last_dir;                   // 1 = right
   logic       nd, l_nxt, r_nxt, j_edge;
   logic [3:0] cnt;
   logic [7:0] slot;

   always_comb begin
      lp   = 1'b0;
      rp   = 1'b0;
      jp   = 1'b0;
      slot = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         slot = keycodes[8*k +: 8];
         if (slot != 8'h00) begin
            lp = lp | (slot == codes[0]);
            rp = rp | (slot == codes[1]);
            jp = jp | (slot == codes[2]);
         end
      end
   end

   // Simultaneous left/right press edges resolve to right.
   always_comb begin
      nd = last_dir;
      if (rp && !r_prev)      nd = 1'b1;
      else if (lp && !l_prev) nd = 1'b0;
      if (LR_MODE == 0) begin
         l_nxt = lp & ~rp;
         r_nxt = rp & ~lp;
      end else begin
         l_nxt = lp & (~rp | ~nd);
         r_nxt = rp & (~lp | nd);
      end
      j_edge = jp & ~j_prev;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         l_prev     <= 1'b0;
         r_prev     <= 1'b0;
         j_prev     <= 1'b0;
         last_dir   <= 1'b0;
         left       <= 1'b0;
         right      <= 1'b0;
         jump_held  <= 1'b0;
         jump_pulse <= 1'b0;
         jump_req   <= 1'b0;
         cnt        <= 4'd0;
      end else begin
         jump_pulse <= 1'b0;
         if (tick) begin
            l_prev     <= lp;
            r_prev     <= rp;
            j_prev     <= jp;
            last_dir   <= nd;
            left       <= l_nxt;
            right      <= r_nxt;
            jump_held  <= jp;
            jump_pulse <= j_edge;
         end
         // A fresh press outranks an ack arriving on the same edge.
         if (tick && j_edge) begin
            jump_req <= 1'b1;
            cnt      <= 4'(JUMP_BUF);
         end else if (ack) begin
            jump_req <= 1'b0;
            cnt      <= 4'd0;
         end else if (tick && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) jump_req <= 1'b0;
         end
      end
   end
endmodule

module keycode_action_mapper #(
   parameter int NUM_KEYS    = 6,
   parameter int NUM_PLAYERS = 2,
   parameter int JUMP_BUF    = 4,
   parameter int LR_MODE     = 0
) (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   keycode_action_mapper_if.slave bus
);
   logic [1:0]                        fsync;
   logic                              fhist;
   logic                              frame_tick;
   logic [NUM_PLAYERS-1:0][2:0][7:0]  tbl;
   logic [NUM_PLAYERS-1:0]            left_v, right_v, held_v, pulse_v, req_v;

   function automatic logic [7:0] dflt(input int p, input int a);
      logic [7:0] c;
      c = 8'h00;
      if (p == 0)      c = (a == 0) ? 8'h04 : (a == 1) ? 8'h07 : 8'h1A;
      else if (p == 1) c = (a == 0) ? 8'h50 : (a == 1) ? 8'h4F : 8'h52;
      return c;
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fsync <= 2'b00;
         fhist <= 1'b0;
      end else begin
         fsync <= {fsync[0], frame_clk};
         fhist <= fsync[1];
      end
   end
   assign frame_tick = fsync[1] & ~fhist;

   // Out-of-range players and action 3 simply never match the loop indices.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            for (int a = 0; a < 3; a++)
               tbl[p][a] <= dflt(p, a);
      end else if (bus.cfg_we) begin
         for (int p = 0; p < NUM_PLAYERS; p++)
            for (int a = 0; a < 3; a++)
               if (bus.cfg_player == 3'(p) && bus.cfg_action == 2'(a))
                  tbl[p][a] <= bus.cfg_code;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)           bus.any_key <= 1'b0;
      else if (frame_tick) bus.any_key <= |bus.keycodes;
   end

   for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
      keycode_action_mapper_lane #(
         .NUM_KEYS (NUM_KEYS),
         .JUMP_BUF (JUMP_BUF),
         .LR_MODE  (LR_MODE)
      ) u_lane (
         .Clk        (Clk),
         .Reset      (Reset),
         .tick       (frame_tick),
         .keycodes   (bus.keycodes),
         .codes      (tbl[p]),
         .ack        (bus.jump_ack[p]),
         .left       (left_v[p]),
         .right      (right_v[p]),
         .jump_held  (held_v[p]),
         .jump_pulse (pulse_v[p]),
         .jump_req   (req_v[p])
      );
   end

   assign bus.left       = left_v;
   assign bus.right      = right_v;
   assign bus.jump_held  = held_v;
   assign bus.jump_pulse = pulse_v;
   assign bus.jump_req   = req_v;
endmodule

// File: tb/tb_keycode_action_mapper.sv
// Directed bench: two mappers (cancel and last-pressed-wins) share one stimulus stream.
module tb_keycode_action_mapper;
   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_clk = 1'b0;
   logic [47:0] keys = '0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_player = '0;
   logic [1:0]  cfg_action = '0;
   logic [7:0]  cfg_code = '0;
   logic [1:0]  ack = '0;
   int          n_cmp = 0;
   int          n_bad = 0;

   keycode_action_mapper_if #(.NUM_KEYS(6), .NUM_PLAYERS(2)) kb0 ();
   keycode_action_mapper_if #(.NUM_KEYS(6), .NUM_PLAYERS(2)) kb1 ();

   assign kb0.keycodes = keys;   assign kb1.keycodes = keys;
   assign kb0.cfg_we = cfg_we;   assign kb1.cfg_we = cfg_we;
   assign kb0.cfg_player = cfg_player; assign kb1.cfg_player = cfg_player;
   assign kb0.cfg_action = cfg_action; assign kb1.cfg_action = cfg_action;
   assign kb0.cfg_code = cfg_code;     assign kb1.cfg_code = cfg_code;
   assign kb0.jump_ack = ack;    assign kb1.jump_ack = ack;

   keycode_action_mapper #(.NUM_KEYS(6), .NUM_PLAYERS(2), .JUMP_BUF(4), .LR_MODE(0))
      dut0 (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(kb0));
   keycode_action_mapper #(.NUM_KEYS(6), .NUM_PLAYERS(2), .JUMP_BUF(4), .LR_MODE(1))
      dut1 (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(kb1));

   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] mk(input logic [7:0] a, input logic [7:0] b);
      return {32'h0, b, a};
   endfunction

   task automatic do_reset();
      @(negedge Clk); Reset = 1'b1; keys = '0; ack = '0; frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
   endtask

   // Returns at the negedge where frame_tick is high, before the sampling edge.
   task automatic frame_up();
      repeat (4) @(negedge Clk);
      frame_clk = 1'b1;
      @(negedge Clk); @(negedge Clk);
   endtask

   // Returns just after the sampling edge.
   task automatic frame_done();
      @(negedge Clk); frame_clk = 1'b0;
   endtask

   task automatic frame();
      frame_up(); frame_done();
   endtask

   task automatic write_cfg(input logic [2:0] p, input logic [1:0] a, input logic [7:0] c);
      @(negedge Clk); cfg_we = 1'b1; cfg_player = p; cfg_action = a; cfg_code = c;
      @(negedge Clk); cfg_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      chk("rst_left", kb0.left, 2'b00);
      chk("rst_req", kb0.jump_req, 2'b00);
      chk("rst_any", kb0.any_key, 1'b0);
      Reset = 1'b0;

      // Single left key: nothing before the tick, update on the tick edge
      keys = mk(8'h04, 8'h00);
      frame_up();
      chk("pre_tick_left", kb0.left, 2'b00);
      chk("pre_tick_any", kb0.any_key, 1'b0);
      frame_done();
      chk("tick_left", kb0.left, 2'b01);
      chk("tick_right", kb0.right, 2'b00);
      chk("tick_any", kb0.any_key, 1'b1);

      // Opposing directions
      keys = mk(8'h04, 8'h07); frame();
      chk("m0_both_left", kb0.left, 2'b00);
      chk("m0_both_right", kb0.right, 2'b00);
      chk("m1_B_right", kb1.right, 2'b01);
      chk("m1_B_left", kb1.left, 2'b00);
      keys = mk(8'h07, 8'h04); frame();
      chk("m1_C_right", kb1.right, 2'b01);
      keys = mk(8'h04, 8'h00); frame();
      chk("m1_D_left", kb1.left, 2'b01);
      chk("m1_D_right", kb1.right, 2'b00);

      // Held jump for three frames
      do_reset();
      keys = mk(8'h52, 8'h00); frame();
      chk("hold_pulse1", kb0.jump_pulse, 2'b10);
      chk("hold_held1", kb0.jump_held, 2'b10);
      @(negedge Clk);
      chk("hold_pulse_drop", kb0.jump_pulse, 2'b00);
      frame();
      chk("hold_pulse2", kb0.jump_pulse, 2'b00);
      chk("hold_held2", kb0.jump_held, 2'b10);
      frame();
      chk("hold_held3", kb0.jump_held, 2'b10);
      chk("hold_req", kb0.jump_req, 2'b10);

      // Jump buffer expiry
      do_reset();
      keys = mk(8'h1A, 8'h00); frame();
      chk("buf_set", kb0.jump_req, 2'b01);
      keys = '0;
      frame(); frame(); frame();
      chk("buf_tick3", kb0.jump_req, 2'b01);
      frame();
      chk("buf_tick4", kb0.jump_req, 2'b00);

      // Ack one cycle after the press
      do_reset();
      keys = mk(8'h1A, 8'h00); frame();
      ack = 2'b01;
      @(negedge Clk); ack = 2'b00;
      chk("ack_clear", kb0.jump_req, 2'b00);

      // Ack coincident with a press edge
      do_reset();
      keys = mk(8'h1A, 8'h00);
      frame_up();
      ack = 2'b01;
      frame_done();
      ack = 2'b00;
      chk("ack_edge_req", kb0.jump_req, 2'b01);
      frame(); frame(); frame();
      chk("ack_edge_cnt", kb0.jump_req, 2'b01);

      // Table write coincident with the tick uses the old table
      do_reset();
      keys = mk(8'h2C, 8'h00);
      frame_up();
      cfg_we = 1'b1; cfg_player = 3'd0; cfg_action = 2'd2; cfg_code = 8'h2C;
      frame_done();
      cfg_we = 1'b0;
      chk("cfg_same_pulse", kb0.jump_pulse, 2'b00);
      chk("cfg_same_held", kb0.jump_held, 2'b00);
      frame();
      chk("cfg_next_pulse", kb0.jump_pulse, 2'b01);

      // Ignored writes: out-of-range player and action 3
      do_reset();
      write_cfg(3'd5, 2'd0, 8'h10);
      write_cfg(3'd0, 2'd3, 8'h33);
      keys = mk(8'h04, 8'h10); frame();
      chk("inv_left", kb0.left, 2'b01);
      chk("inv_right", kb0.right, 2'b00);
      keys = mk(8'h33, 8'h00); frame();
      chk("inv_a3_left", kb0.left, 2'b00);
      chk("inv_a3_held", kb0.jump_held, 2'b00);

      // One code bound to several players/actions
      write_cfg(3'd1, 2'd2, 8'h04);
      keys = mk(8'h04, 8'h00); frame();
      chk("multi_left", kb0.left, 2'b01);
      chk("multi_held", kb0.jump_held, 2'b10);

      // Reset mid-hold
      do_reset();
      keys = mk(8'h52, 8'h00); frame(); frame();
      chk("mid_held", kb0.jump_held, 2'b10);
      @(negedge Clk); Reset = 1'b1;
      #1;
      chk("mid_rst_held", kb0.jump_held, 2'b00);
      chk("mid_rst_req", kb0.jump_req, 2'b00);
      @(negedge Clk); Reset = 1'b0;
      frame();
      chk("mid_repulse", kb0.jump_pulse, 2'b10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
